input_control_unit: RTL and testbench

- Upstream front-end for the on-board message display and the scaling datapath.
- Synchronizes and debounces the four algorithm slide switches and the two zoom push-buttons.
- Decodes a one-hot switch selection into algorithm_select and tracks a zoom level.
- Produces the three error flags the scrolling text display consumes, plus a one-cycle pulse telling the scaler its configuration changed.

---
 rtl/input_control_unit.sv | 140 ++++++++++++++
 tb/tb_input_control_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_control_unit.sv
// Input front-end: synchronizes and debounces the algorithm switches and zoom keys,
// decodes the algorithm selection and maintains the zoom level with its error flags.
module input_control_unit #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       key_zoom_in,
    input  logic       key_zoom_out,
    output logic [1:0] algorithm_select,
    output logic [2:0] zoom_level,
    output logic       invalid_zoom_error,
    output logic       multiple_switches_error,
    output logic       no_switch_selected_error,
    output logic       config_update
);

    localparam int              N_LINES    = 6;
    // Idle level of each line: switches off, keys released (active-low).
    localparam logic [N_LINES-1:0] IDLE_LINES = 6'b110000;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]         ZOOM_1X    = 3'd2;

    logic [N_LINES-1:0] raw;
    logic [N_LINES-1:0] sync1;
    logic [N_LINES-1:0] sync2;
    logic [N_LINES-1:0] stable;
    logic [CNT_W-1:0]   cnt [N_LINES];
    logic [1:0]         key_d;

    logic [2:0] sw_count;
    logic [1:0] sw_index;
    logic       press_in;
    logic       press_out;
    logic [2:0] zoom_up;
    logic [2:0] zoom_dn;
    logic       upscale;
    logic       in_ok;
    logic       out_ok;

    assign raw = {key_zoom_out, key_zoom_in, sw};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1  <= IDLE_LINES;
            sync2  <= IDLE_LINES;
            stable <= IDLE_LINES;
            key_d  <= IDLE_LINES[5:4];
            // NOTE: cnt is a small array of flops, not a RAM, so it is safe to clear in reset.
            for (int i = 0; i < N_LINES; i++) cnt[i] <= '0;
        end else begin
            // NOTE: non-blocking here so the sync chain shifts one stage per clock.
            sync1 <= raw;
            sync2 <= sync1;
            key_d <= stable[5:4];
            for (int i = 0; i < N_LINES; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        stable[i] <= sync2[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Press = debounced key falling edge; lasts exactly one cycle.
    assign press_in  = key_d[0] & ~stable[4];
    assign press_out = key_d[1] & ~stable[5];

    always_comb begin
        // NOTE: defaults first so no path through the loop leaves a latch behind.
        sw_count = '0;
        sw_index = '0;
        for (int i = 0; i < 4; i++) begin
            if (stable[i]) begin
                sw_count = sw_count + 3'd1;
                sw_index = 2'(i);
            end
        end
    end

    // Algorithms 0/1 scale up (levels 2..4); 2/3 scale down (levels 0..2).
    always_comb begin
        zoom_up = zoom_level + 3'd1;
        zoom_dn = zoom_level - 3'd1;
        upscale = ~algorithm_select[1];
        in_ok   = (zoom_up <= 3'd4) &&
                  (upscale ? (zoom_up > 3'd2) : (zoom_up <= 3'd2));
        out_ok  = (zoom_level != 3'd0) &&
                  (upscale ? (zoom_dn >= 3'd2) : (zoom_dn < 3'd2));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            algorithm_select         <= 2'd0;
            zoom_level               <= ZOOM_1X;
            invalid_zoom_error       <= 1'b0;
            multiple_switches_error  <= 1'b0;
            no_switch_selected_error <= 1'b0;
            config_update            <= 1'b0;
        end else begin
            config_update            <= 1'b0;
            no_switch_selected_error <= (sw_count == 3'd0);
            multiple_switches_error  <= (sw_count > 3'd1);
            if (sw_count == 3'd1) begin
                if (sw_index != algorithm_select) begin
                    // Algorithm change wins over any coincident press.
                    algorithm_select   <= sw_index;
                    zoom_level         <= ZOOM_1X;
                    invalid_zoom_error <= 1'b0;
                    config_update      <= 1'b1;
                end else if (press_in && !press_out) begin
                    if (in_ok) begin
                        zoom_level         <= zoom_up;
                        invalid_zoom_error <= 1'b0;
                        config_update      <= 1'b1;
                    end else begin
                        invalid_zoom_error <= 1'b1;
                    end
                end else if (press_out && !press_in) begin
                    if (out_ok) begin
                        zoom_level         <= zoom_dn;
                        invalid_zoom_error <= 1'b0;
                        config_update      <= 1'b1;
                    end else begin
                        invalid_zoom_error <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_input_control_unit.sv
// Self-checking bench for input_control_unit: directed scenarios with literal
// expectations, then random stimulus against a behavioural model every cycle.
module tb_input_control_unit;

    localparam int         D    = 4;
    localparam logic [5:0] IDLE = 6'b110000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] sw = 4'b0000;
    logic       key_zoom_in = 1'b1;
    logic       key_zoom_out = 1'b1;
    logic [1:0] algorithm_select;
    logic [2:0] zoom_level;
    logic       invalid_zoom_error;
    logic       multiple_switches_error;
    logic       no_switch_selected_error;
    logic       config_update;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    input_control_unit #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .sw                       (sw),
        .key_zoom_in              (key_zoom_in),
        .key_zoom_out             (key_zoom_out),
        .algorithm_select         (algorithm_select),
        .zoom_level               (zoom_level),
        .invalid_zoom_error       (invalid_zoom_error),
        .multiple_switches_error  (multiple_switches_error),
        .no_switch_selected_error (no_switch_selected_error),
        .config_update            (config_update)
    );

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model. A line's debounced value flips once its sampled raw value
    // has disagreed with it for the last D samples, seen through a 2-sample delay.
    logic [5:0] hist [0:D+1];
    logic [5:0] stab, stab_prev;
    int  m_alg, m_zoom, pop, idx, tgt;
    bit  m_inv, m_multi, m_none, m_cfg, zin, zout, upscale, ok, flip;
    bit  model_valid = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            for (int j = 0; j <= D + 1; j++) hist[j] = IDLE;
            stab = IDLE; stab_prev = IDLE;
            m_alg = 0; m_zoom = 2; m_inv = 0; m_multi = 0; m_none = 0; m_cfg = 0;
            model_valid = 1'b1;
        end else begin
            pop  = $countones(stab[3:0]);
            zin  = stab_prev[4] && !stab[4];
            zout = stab_prev[5] && !stab[5];
            m_cfg   = 0;
            m_none  = (pop == 0);
            m_multi = (pop > 1);
            if (pop == 1) begin
                idx = 0;
                for (int b = 0; b < 4; b++) if (stab[b]) idx = b;
                upscale = (m_alg == 0 || m_alg == 1);
                if (idx != m_alg) begin
                    m_alg = idx; m_zoom = 2; m_inv = 0; m_cfg = 1;
                end else if (zin != zout) begin
                    if (zin) begin
                        tgt = m_zoom + 1;
                        ok  = tgt <= 4 && ((tgt > 2 && upscale) || (tgt <= 2 && !upscale));
                    end else begin
                        tgt = m_zoom - 1;
                        ok  = tgt >= 0 && ((tgt < 2 && !upscale) || (tgt >= 2 && upscale));
                    end
                    if (ok) begin
                        m_zoom = tgt; m_inv = 0; m_cfg = 1;
                    end else begin
                        m_inv = 1;
                    end
                end
            end
            for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = {key_zoom_out, key_zoom_in, sw};
            stab_prev = stab;
            for (int b = 0; b < 6; b++) begin
                flip = 1;
                for (int j = 2; j <= D + 1; j++) if (hist[j][b] == stab_prev[b]) flip = 0;
                if (flip) stab[b] = ~stab_prev[b];
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model algorithm_select", 8'(algorithm_select), 8'(m_alg));
            check("model zoom_level", 8'(zoom_level), 8'(m_zoom));
            check("model invalid_zoom_error", 8'(invalid_zoom_error), 8'(m_inv));
            check("model multiple_switches_error", 8'(multiple_switches_error), 8'(m_multi));
            check("model no_switch_selected_error", 8'(no_switch_selected_error), 8'(m_none));
            check("model config_update", 8'(config_update), 8'(m_cfg));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit zi, input bit zo, input int low_cycles);
        key_zoom_in  = ~zi;
        key_zoom_out = ~zo;
        tick(low_cycles);
        key_zoom_in  = 1'b1;
        key_zoom_out = 1'b1;
        tick(10);
    endtask

    initial begin
        // Reset with no switch selected.
        tick(3);
        reset = 1'b1;
        tick(10);
        check("idle no_switch", 8'(no_switch_selected_error), 8'd1);
        check("idle zoom", 8'(zoom_level), 8'd2);
        check("idle alg", 8'(algorithm_select), 8'd0);

        // Exact latency of 2 + D + 1 cycles from the raw edge.
        sw = 4'b0100;
        tick(6);
        check("alg before latency", 8'(algorithm_select), 8'd0);
        tick(1);
        check("alg at latency", 8'(algorithm_select), 8'd2);
        check("cfg at latency", 8'(config_update), 8'd1);
        tick(1);
        check("cfg one cycle", 8'(config_update), 8'd0);
        sw = 4'b0110;
        tick(8);
        check("multi flag", 8'(multiple_switches_error), 8'd1);
        check("alg held", 8'(algorithm_select), 8'd2);

        // Glitch rejection and zoom-in up to the limit.
        sw = 4'b0001;
        tick(8);
        check("alg0", 8'(algorithm_select), 8'd0);
        key_zoom_in = 1'b0;
        tick(3);
        key_zoom_in = 1'b1;
        tick(10);
        check("glitch zoom", 8'(zoom_level), 8'd2);
        press(1, 0, 10);
        check("zoom in 3", 8'(zoom_level), 8'd3);
        press(1, 0, 8);
        check("zoom in 4", 8'(zoom_level), 8'd4);
        press(1, 0, 8);
        check("zoom in reject lvl", 8'(zoom_level), 8'd4);
        check("zoom in reject err", 8'(invalid_zoom_error), 8'd1);

        // Downscaling algorithm.
        sw = 4'b1000;
        tick(8);
        check("alg3 zoom reset", 8'(zoom_level), 8'd2);
        check("alg3 err cleared", 8'(invalid_zoom_error), 8'd0);
        press(1, 0, 8);
        check("alg3 in reject err", 8'(invalid_zoom_error), 8'd1);
        check("alg3 in reject lvl", 8'(zoom_level), 8'd2);
        press(0, 1, 8);
        check("alg3 out 1", 8'(zoom_level), 8'd1);
        check("alg3 out err clr", 8'(invalid_zoom_error), 8'd0);
        press(0, 1, 8);
        check("alg3 out 0", 8'(zoom_level), 8'd0);
        press(0, 1, 8);
        check("alg3 out reject lvl", 8'(zoom_level), 8'd0);
        check("alg3 out reject err", 8'(invalid_zoom_error), 8'd1);

        // Algorithm change resets zoom and error.
        sw = 4'b0010;
        tick(7);
        check("alg1 cfg", 8'(config_update), 8'd1);
        check("alg1 sel", 8'(algorithm_select), 8'd1);
        check("alg1 zoom", 8'(zoom_level), 8'd2);
        check("alg1 err", 8'(invalid_zoom_error), 8'd0);
        tick(2);

        // Both keys at once are ignored.
        press(1, 1, 8);
        check("both keys zoom", 8'(zoom_level), 8'd2);
        check("both keys err", 8'(invalid_zoom_error), 8'd0);

        // Reset mid-debounce drops the pending change.
        sw = 4'b0100;
        tick(4);
        reset = 1'b0;
        tick(2);
        check("rst alg", 8'(algorithm_select), 8'd0);
        check("rst zoom", 8'(zoom_level), 8'd2);
        check("rst no_switch", 8'(no_switch_selected_error), 8'd0);
        check("rst cfg", 8'(config_update), 8'd0);
        reset = 1'b1;
        tick(6);
        check("post rst alg early", 8'(algorithm_select), 8'd0);
        tick(1);
        check("post rst alg", 8'(algorithm_select), 8'd2);

        // Random stimulus, checked by the model every cycle.
        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6)      sw = 4'b0001 << $urandom_range(0, 3);
            else if (r < 8) sw = 4'($urandom_range(0, 15));
            key_zoom_in  = ($urandom_range(0, 9) >= 4);
            key_zoom_out = ($urandom_range(0, 9) >= 5);
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b0;
                tick(1);
                reset = 1'b1;
            end
            tick(int'($urandom_range(1, 10)));
        end
        tick(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
